// File: rtl/obi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// obi_ram_arbiter
//
// Shares one single-port RAM between two OBI requesters:
//   m0 = core instruction port, m1 = core data port.
// Round-robin arbitration, an address-window check and fixed one-cycle
// response routing back to the requester that was granted.
//
// Handshake: a requester's mX_req is accepted in the same cycle that
// mX_gnt is high (combinational, no wait states). Exactly one cycle after
// every grant, mX_rvalid pulses on the granted port, with mX_err set if the
// address was outside the RAM window. Responses are never stalled, so
// back-to-back grants produce back-to-back responses in grant order.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   mX_req/gnt          OBI request / grant (X = 0,1)
//   mX_we/be/addr/wdata OBI request attributes
//   mX_rvalid/rdata/err OBI response
//   ram_req/we/be/addr/wdata  RAM access (all zero when no in-window access)
//   ram_rvalid/rdata    RAM response (data one cycle after ram_req)
// -----------------------------------------------------------------------------
module obi_ram_arbiter #(
    parameter int            DW        = 32,
    parameter int            AW        = 32,
    parameter int            SW        = 4,
    parameter int            RAM_AW    = 14,
    parameter logic [AW-1:0] ADDR_BASE = 32'h4000,
    parameter logic [AW-1:0] ADDR_SIZE = 32'h4000
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    output logic              m0_gnt,
    input  logic              m0_we,
    input  logic [SW-1:0]     m0_be,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    output logic              m0_rvalid,
    output logic [DW-1:0]     m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    output logic              m1_gnt,
    input  logic              m1_we,
    input  logic [SW-1:0]     m1_be,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    output logic              m1_rvalid,
    output logic [DW-1:0]     m1_rdata,
    output logic              m1_err,

    output logic              ram_req,
    output logic              ram_we,
    output logic [SW-1:0]     ram_be,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic              ram_rvalid,
    input  logic [DW-1:0]     ram_rdata
);

    // 1 = m1 held the most recent grant. Resets to 1 so m0 wins first contention.
    logic          last_gnt;
    logic          win_m1;
    logic          any_gnt;

    logic          sel_we;
    logic [SW-1:0] sel_be;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          in_win;

    logic          rsp_valid_q;
    logic          rsp_owner_q;
    logic          rsp_err_q;
    logic          rsp_read_q;
    logic          rsp_live;

    // m1 wins when it is the only requester, or on contention when m0 was
    // the most recent winner.
    always_comb begin
        win_m1 = 1'b0;
        if (m1_req && (!m0_req || !last_gnt)) begin
            win_m1 = 1'b1;
        end
    end

    assign m0_gnt  = m0_req & ~win_m1 & ~rst;
    assign m1_gnt  = m1_req &  win_m1 & ~rst;
    assign any_gnt = m0_gnt | m1_gnt;

    assign sel_we    = win_m1 ? m1_we    : m0_we;
    assign sel_be    = win_m1 ? m1_be    : m0_be;
    assign sel_addr  = win_m1 ? m1_addr  : m0_addr;
    assign sel_wdata = win_m1 ? m1_wdata : m0_wdata;

    // One extra bit keeps ADDR_BASE + ADDR_SIZE from wrapping at the top of the map.
    assign in_win = ({1'b0, sel_addr} >= {1'b0, ADDR_BASE}) &&
                    ({1'b0, sel_addr} <  ({1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE}));

    always_comb begin
        ram_req   = 1'b0;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (any_gnt && in_win) begin
            ram_req   = 1'b1;
            ram_we    = sel_we;
            ram_be    = sel_be;
            // Only the low RAM_AW bits of the offset survive, so subtract in that width.
            ram_addr  = sel_addr[RAM_AW-1:0] - ADDR_BASE[RAM_AW-1:0];
            ram_wdata = sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt    <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_read_q  <= 1'b0;
        end else begin
            rsp_valid_q <= any_gnt;
            if (any_gnt) begin
                last_gnt    <= win_m1;
                rsp_owner_q <= win_m1;
                rsp_err_q   <= ~in_win;
                rsp_read_q  <= in_win & ~sel_we;
            end
        end
    end

    // A response pending while reset is asserted is dropped, not delivered.
    assign rsp_live = rsp_valid_q & ~rst;

    assign m0_rvalid = rsp_live & ~rsp_owner_q;
    assign m1_rvalid = rsp_live &  rsp_owner_q;
    assign m0_err    = m0_rvalid & rsp_err_q;
    assign m1_err    = m1_rvalid & rsp_err_q;
    // Writes and errors return zero data rather than whatever the RAM drives.
    assign m0_rdata  = (m0_rvalid && rsp_read_q) ? ram_rdata : '0;
    assign m1_rdata  = (m1_rvalid && rsp_read_q) ? ram_rdata : '0;

`ifndef SYNTHESIS
    // Routing relies on fixed RAM latency; the RAM must answer exactly the
    // in-window accesses issued one cycle earlier.
    always @(posedge clk) begin
        if (!rst) begin
            assert (ram_rvalid == (rsp_valid_q & ~rsp_err_q));
        end
    end
`endif

endmodule

// File: tb/tb_obi_ram_arbiter.sv
module tb_obi_ram_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int RAM_AW = 14;
  localparam longint BASE = 64'h4000;
  localparam longint SIZE = 64'h4000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic              m0_req, m0_gnt, m0_we, m0_rvalid, m0_err;
  logic [SW-1:0]     m0_be;
  logic [AW-1:0]     m0_addr;
  logic [DW-1:0]     m0_wdata, m0_rdata;
  logic              m1_req, m1_gnt, m1_we, m1_rvalid, m1_err;
  logic [SW-1:0]     m1_be;
  logic [AW-1:0]     m1_addr;
  logic [DW-1:0]     m1_wdata, m1_rdata;
  logic              ram_req, ram_we, ram_rvalid;
  logic [SW-1:0]     ram_be;
  logic [RAM_AW-1:0] ram_addr;
  logic [DW-1:0]     ram_wdata, ram_rdata;

  obi_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_we(m0_we), .m0_be(m0_be),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_we(m1_we), .m1_be(m1_be),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata)
  );

  // ---------------- RAM device (1-cycle read latency) ----------------
  logic [31:0] ram_mem [4096];

  initial begin
    for (int w = 0; w < 4096; w++) ram_mem[w] = 32'hA500_0000 | w;
  end

  always @(posedge clk) begin
    ram_rvalid <= ram_req;
    if (ram_req && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram_mem[ram_addr[13:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= $urandom;
    end else if (ram_req) begin
      ram_rdata <= ram_mem[ram_addr[13:2]];
    end else begin
      ram_rdata <= $urandom;   // junk: must never reach a requester
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // Byte-addressed image of the RAM window, kept by the model from the
  // accesses it expects to happen.
  logic [7:0]  ref_mem [16384];
  // Pending response: {owner, err, data}
  logic [33:0] exp_q[$];
  bit          last_m;     // which port was granted most recently
  bit          has_rsp;
  logic [33:0] e;
  bit          w0, w1, xwe, inwin;
  logic [3:0]  xbe;
  logic [31:0] xaddr, xwdata, xdata, off;
  int          a;

  initial begin
    for (int w = 0; w < 4096; w++)
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = 8'((32'hA500_0000 | w) >> (8*b));
    last_m = 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_m = 1'b1;
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m1_rvalid", m1_rvalid, 0);
      chk("rst_m0_err", m0_err, 0);
      chk("rst_m1_err", m1_err, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
      chk("rst_m1_rdata", m1_rdata, 0);
      chk("rst_ram_req", ram_req, 0);
    end else begin
      // response to last cycle's grant
      has_rsp = (exp_q.size() != 0);
      e = has_rsp ? exp_q.pop_front() : 34'd0;
      chk("m0_rvalid", m0_rvalid, has_rsp && !e[33]);
      chk("m1_rvalid", m1_rvalid, has_rsp &&  e[33]);
      chk("m0_err", m0_err, has_rsp && !e[33] && e[32]);
      chk("m1_err", m1_err, has_rsp &&  e[33] && e[32]);
      chk("m0_rdata", m0_rdata, (has_rsp && !e[33]) ? e[31:0] : 32'd0);
      chk("m1_rdata", m1_rdata, (has_rsp &&  e[33]) ? e[31:0] : 32'd0);

      // who gets this cycle: lone requester wins; contention goes to the
      // port that did not win last time
      if (m0_req && m1_req) begin
        w0 = (last_m == 1'b1);
        w1 = !w0;
      end else begin
        w0 = m0_req;
        w1 = m1_req;
      end
      chk("m0_gnt", m0_gnt, w0);
      chk("m1_gnt", m1_gnt, w1);

      if (w0 || w1) begin
        xwe    = w1 ? m1_we    : m0_we;
        xbe    = w1 ? m1_be    : m0_be;
        xaddr  = w1 ? m1_addr  : m0_addr;
        xwdata = w1 ? m1_wdata : m0_wdata;
        inwin  = (longint'(xaddr) >= BASE) && (longint'(xaddr) < BASE + SIZE);
        off    = xaddr - 32'(BASE);
        xdata  = 32'd0;
        chk("ram_req", ram_req, inwin);
        chk("ram_we", ram_we, inwin ? xwe : 1'b0);
        chk("ram_be", ram_be, inwin ? xbe : 4'd0);
        chk("ram_addr", ram_addr, inwin ? off[13:0] : 14'd0);
        chk("ram_wdata", ram_wdata, inwin ? xwdata : 32'd0);
        if (inwin) begin
          a = int'(off[13:0]) & ~3;
          if (xwe) begin
            for (int b = 0; b < 4; b++) if (xbe[b]) ref_mem[a + b] = xwdata[8*b +: 8];
          end else begin
            xdata = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
          end
        end
        exp_q.push_back({w1, !inwin, xdata});
        last_m = w1;
      end else begin
        chk("idle_ram_req", ram_req, 0);
        chk("idle_ram_we", ram_we, 0);
        chk("idle_ram_be", ram_be, 0);
        chk("idle_ram_addr", ram_addr, 0);
        chk("idle_ram_wdata", ram_wdata, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic drive_m0(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd);
    m0_req = 1; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd;
  endtask

  task automatic drive_m1(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd);
    m1_req = 1; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = 32'h4000 + ($urandom_range(0, 63) << 2);
      1: r = 32'h4000 + $urandom_range(0, 32'h3FFF);
      2: case ($urandom_range(0, 6))
           0: r = 32'h3FFC;
           1: r = 32'h3FFF;
           2: r = 32'h7FFC;
           3: r = 32'h7FFF;
           4: r = 32'h8000;
           5: r = 32'hFFFF_FFFF;
           default: r = 32'h0;
         endcase
      default: r = $urandom;
    endcase
    return r;
  endfunction

  task automatic rand_m0();
    m0_req = ($urandom_range(0, 9) < 7); m0_we = 1'($urandom_range(0, 1));
    m0_be = 4'($urandom_range(0, 15)); m0_addr = rand_addr(); m0_wdata = $urandom;
  endtask

  task automatic rand_m1();
    m1_req = ($urandom_range(0, 9) < 7); m1_we = 1'($urandom_range(0, 1));
    m1_be = 4'($urandom_range(0, 15)); m1_addr = rand_addr(); m1_wdata = $urandom;
  endtask

  // ---------------- stimulus ----------------
  bit g0, g1;

  initial begin
    rst = 1;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;

    // continuous contention from reset release alternates m0, m1
    drive_m0(0, 4'hF, 32'h4000, 0);
    drive_m1(0, 4'hF, 32'h4004, 0);
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("alt_m0_gnt", m0_gnt, (i % 2) == 0);
      chk("alt_m1_gnt", m1_gnt, (i % 2) == 1);
      if (i > 0) begin
        chk("alt_m0_rvalid", m0_rvalid, (i % 2) == 1);
        chk("alt_m1_rvalid", m1_rvalid, (i % 2) == 0);
      end
      tick();
    end
    idle_all();

    // m0 partial write
    drive_m0(1, 4'b0011, 32'h4004, 32'hDEAD_BEEF);
    #2;
    chk("wr_gnt", m0_gnt, 1);
    chk("wr_ram_req", ram_req, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_be", ram_be, 4'b0011);
    chk("wr_ram_addr", ram_addr, 14'h0004);
    chk("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    tick();
    idle_all();
    #2;
    chk("wr_rvalid", m0_rvalid, 1);
    chk("wr_err", m0_err, 0);
    chk("wr_rdata", m0_rdata, 0);
    tick();

    // m1 read in window, m0 idle
    drive_m1(0, 4'hF, 32'h4010, 0);
    #2;
    chk("rd_m1_gnt", m1_gnt, 1);
    chk("rd_m0_gnt", m0_gnt, 0);
    chk("rd_ram_req", ram_req, 1);
    chk("rd_ram_addr", ram_addr, 14'h0010);
    chk("rd_ram_we", ram_we, 0);
    tick();
    idle_all();
    #2;
    chk("rd_m1_rvalid", m1_rvalid, 1);
    chk("rd_m1_rdata", m1_rdata, 32'hA500_0004);
    chk("rd_m1_err", m1_err, 0);
    chk("rd_m0_rvalid", m0_rvalid, 0);
    tick();

    // m1 read out of window
    drive_m1(0, 4'hF, 32'h9000, 0);
    #2;
    chk("oow_gnt", m1_gnt, 1);
    chk("oow_ram_req", ram_req, 0);
    chk("oow_ram_addr", ram_addr, 0);
    tick();
    idle_all();
    #2;
    chk("oow_rvalid", m1_rvalid, 1);
    chk("oow_err", m1_err, 1);
    chk("oow_rdata", m1_rdata, 0);
    tick();

    // m0 back-to-back reads
    drive_m0(0, 4'hF, 32'h4000, 0);
    #2;
    chk("b2b_gnt0", m0_gnt, 1);
    tick();
    drive_m0(0, 4'hF, 32'h4004, 0);
    #2;
    chk("b2b_gnt1", m0_gnt, 1);
    chk("b2b_rdata0", m0_rdata, 32'hA500_0000);
    tick();
    drive_m0(0, 4'hF, 32'h4008, 0);
    #2;
    chk("b2b_gnt2", m0_gnt, 1);
    chk("b2b_rdata1", m0_rdata, 32'hA500_BEEF);
    tick();
    idle_all();
    #2;
    chk("b2b_rvalid2", m0_rvalid, 1);
    chk("b2b_rdata2", m0_rdata, 32'hA500_0002);
    tick();

    // reset while a response is pending
    drive_m0(0, 4'hF, 32'h4000, 0);
    #2;
    chk("rp_gnt", m0_gnt, 1);
    tick();
    idle_all();
    rst = 1;
    #2;
    chk("rp_rvalid_in_rst", m0_rvalid, 0);
    tick();
    #2;
    chk("rp_rvalid_rst2", m0_rvalid, 0);
    tick();
    rst = 0;
    drive_m0(0, 4'hF, 32'h4000, 0);
    drive_m1(0, 4'hF, 32'h4004, 0);
    #2;
    chk("rp_m0_first", m0_gnt, 1);
    chk("rp_m1_first", m1_gnt, 0);
    chk("rp_no_rvalid", m0_rvalid, 0);
    tick();
    #2;
    chk("rp_m1_second", m1_gnt, 1);
    chk("rp_m0_rvalid", m0_rvalid, 1);
    tick();
    idle_all();

    // randomized traffic; a requester holds its request until granted
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      tick();
      if ($urandom_range(0, 99) == 0) begin
        rst = 1;
        m0_req = 0;
        m1_req = 0;
      end else begin
        rst = 0;
        if (!m0_req || g0) rand_m0();
        if (!m1_req || g1) rand_m1();
      end
    end

    rst = 0;
    idle_all();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
